// File: rtl/edgcol_pkg.sv
// Shared types and constants for the edge-collision load sequencer.
// Also sizes the edge register file write port.
package edgcol_pkg;

  localparam int NUM_EDGES   = 6;
  localparam int EDGE_ADDR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    RESP
  } seqState_t;

  // Watchdog counter width; a disabled watchdog
  // still needs one bit to stay a legal vector.
  function automatic int wdWidth(input int timeout);
    if (timeout < 1) return 1;
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/edgcol_watchdog.sv
// Saturating WAIT-phase watchdog for the load sequencer.
// Ports: clk, rst (async low), clear, enable -> expired.
module edgcol_watchdog
  import edgcol_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = wdWidth(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != W'(TIMEOUT)) begin
      count <= count + W'(1);
    end
  end

  // Fires on the last permitted WAIT cycle so the
  // sequencer leaves WAIT after exactly TIMEOUT cycles.
  always_comb begin
    expired = (TIMEOUT != 0) && (count == W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/edgcol_load_sequencer.sv
// Loads edge words into the regfile, starts the collision unit,
// waits under a watchdog and hands the result back to the core.
// Ports: start/abort control, in_* edge stream, wr* regfile port,
// chk_* collision unit, res_* result handshake, busy status.
module edgcol_load_sequencer
  import edgcol_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NUM_EDGES = edgcol_pkg::NUM_EDGES,
  parameter int ADDR_W    = EDGE_ADDR_W,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in_data,
  output logic                 wrEna,
  output logic [ADDR_W-1:0]    wrAddr,
  output logic [REG_WIDTH-1:0] wrData,
  output logic                 chk_start,
  input  logic                 chk_done,
  input  logic                 chk_collide,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_collide,
  output logic                 res_timeout,
  output logic                 busy
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_EDGES - 1);

  seqState_t state;
  seqState_t stateNxt;

  logic [ADDR_W-1:0]    cnt;
  logic [ADDR_W-1:0]    cntNxt;
  logic                 wrEnaNxt;
  logic [ADDR_W-1:0]    wrAddrNxt;
  logic [REG_WIDTH-1:0] wrDataNxt;
  logic                 chkStartNxt;
  logic                 resValidNxt;
  logic                 resCollideNxt;
  logic                 resTimeoutNxt;
  logic                 inReadyNxt;
  logic                 busyNxt;
  logic                 beat;
  logic                 wdExpired;

  assign beat = in_valid & in_ready;

  edgcol_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .expired(wdExpired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wrEna       <= 1'b0;
      wrAddr      <= '0;
      wrData      <= '0;
      chk_start   <= 1'b0;
      res_valid   <= 1'b0;
      res_collide <= 1'b0;
      res_timeout <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= stateNxt;
      cnt         <= cntNxt;
      wrEna       <= wrEnaNxt;
      wrAddr      <= wrAddrNxt;
      wrData      <= wrDataNxt;
      chk_start   <= chkStartNxt;
      res_valid   <= resValidNxt;
      res_collide <= resCollideNxt;
      res_timeout <= resTimeoutNxt;
      in_ready    <= inReadyNxt;
      busy        <= busyNxt;
    end
  end

  always_comb begin
    stateNxt      = state;
    cntNxt        = cnt;
    wrEnaNxt      = 1'b0;
    wrAddrNxt     = wrAddr;
    wrDataNxt     = wrData;
    chkStartNxt   = 1'b0;
    resValidNxt   = res_valid;
    resCollideNxt = res_collide;
    resTimeoutNxt = res_timeout;
    inReadyNxt    = 1'b0;

    // Abort beats every in-flight event, including
    // a beat or a result acceptance in the same cycle.
    if (abort && state != IDLE) begin
      stateNxt    = IDLE;
      cntNxt      = '0;
      resValidNxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            stateNxt      = LOAD;
            cntNxt        = '0;
            inReadyNxt    = 1'b1;
            resCollideNxt = 1'b0;
            resTimeoutNxt = 1'b0;
          end
        end
        LOAD: begin
          inReadyNxt = 1'b1;
          if (beat) begin
            wrEnaNxt  = 1'b1;
            wrAddrNxt = cnt;
            wrDataNxt = in_data;
            cntNxt    = cnt + ADDR_W'(1);
            if (cnt == LAST) begin
              stateNxt   = ISSUE;
              inReadyNxt = 1'b0;
            end
          end
        end
        ISSUE: begin
          // The last write is on the port now, so the
          // collision unit starts only after it commits.
          stateNxt    = WAIT;
          chkStartNxt = 1'b1;
        end
        WAIT: begin
          if (chk_done) begin
            stateNxt      = RESP;
            resValidNxt   = 1'b1;
            resCollideNxt = chk_collide;
            resTimeoutNxt = 1'b0;
          end else if (wdExpired) begin
            stateNxt      = RESP;
            resValidNxt   = 1'b1;
            resCollideNxt = 1'b0;
            resTimeoutNxt = 1'b1;
          end
        end
        RESP: begin
          if (res_ready) begin
            stateNxt    = IDLE;
            resValidNxt = 1'b0;
          end
        end
        default: begin
          stateNxt    = IDLE;
          resValidNxt = 1'b0;
        end
      endcase
    end

    busyNxt = (stateNxt != IDLE);
  end

endmodule
